// File: rtl/mul16x9_seq_if.sv
// Handshake and datapath bundle for the 16x9 sequential multiplier controller.
//   in_valid/in_ready/in_a/in_b     : operand pair handshake
//   pp[0..8]                        : unshifted partial products to the external CSA
//   csa_sum/csa_carry               : redundant result returned by the CSA
//   out_valid/out_ready/out_prod    : product handshake
//   busy                            : controller not idle
// modport master : the controller side
// modport slave  : the environment side (operand source, CSA, downstream sink)
interface mul16x9_seq_if;
    logic              in_valid;
    logic              in_ready;
    logic [15:0]       in_a;
    logic [8:0]        in_b;
    logic [8:0][15:0]  pp;
    logic [23:0]       csa_sum;
    logic [24:0]       csa_carry;
    logic              out_valid;
    logic              out_ready;
    logic [24:0]       out_prod;
    logic              busy;

    modport master (
        input  in_valid, in_a, in_b, csa_sum, csa_carry, out_ready,
        output in_ready, pp, out_valid, out_prod, busy
    );

    modport slave (
        output in_valid, in_a, in_b, csa_sum, csa_carry, out_ready,
        input  in_ready, pp, out_valid, out_prod, busy
    );
endinterface

// File: rtl/mul16x9_seq.sv
// Sequencing controller for the 16x9 unsigned multiplier.
// Accepts an operand pair, presents nine gated partial products to the
// external carry-save adder for one cycle, captures the redundant sum/carry
// pair and resolves it with a two-cycle split carry-propagate add, then holds
// the 25-bit product on a valid/ready handshake.
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : mul16x9_seq_if.master (operand, CSA and product signals)
module mul16x9_seq #(
    parameter int unsigned LO_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    mul16x9_seq_if.master      bus
);

    localparam int unsigned PROD_W = 25;
    localparam int unsigned HI_W   = PROD_W - LO_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_PP     = 3'd1;
    localparam logic [2:0] S_ADD_LO = 3'd2;
    localparam logic [2:0] S_ADD_HI = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [8:0][15:0]   r_pp;
    logic [23:0]        r_s;
    logic [24:0]        r_c;
    logic [PROD_W-1:0]  r_res;
    logic               r_cy;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_busy;
    logic [LO_W:0]      w_lo_sum;
    logic [HI_W-1:0]    w_hi_sum;

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (bus.in_valid) w_state_nxt = S_PP;
            S_PP:     w_state_nxt = S_ADD_LO;
            S_ADD_LO: w_state_nxt = S_ADD_HI;
            S_ADD_HI: w_state_nxt = S_DONE;
            S_DONE:   if (bus.out_ready) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Split carry-propagate add; carry bit 0 is forced to zero
    assign w_lo_sum = {1'b0, r_s[LO_W-1:0]} + {1'b0, r_c[LO_W-1:1], 1'b0};
    assign w_hi_sum = {1'b0, r_s[23:LO_W]} + r_c[PROD_W-1:LO_W]
                    + {{(HI_W-1){1'b0}}, r_cy};

    // State register, datapath registers and registered output decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_pp        <= '0;
            r_s         <= '0;
            r_c         <= '0;
            r_res       <= '0;
            r_cy        <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == S_IDLE);
            r_out_valid <= (w_state_nxt == S_DONE);
            r_busy      <= (w_state_nxt != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    // Partial products double as the operand registers;
                    // they are live only during the PP cycle
                    if (bus.in_valid) begin
                        for (int i = 0; i < 9; i++) begin
                            r_pp[i] <= bus.in_b[i] ? bus.in_a : 16'h0000;
                        end
                    end
                end
                S_PP: begin
                    r_s  <= bus.csa_sum;
                    r_c  <= {bus.csa_carry[24:1], 1'b0};
                    r_pp <= '0;
                end
                S_ADD_LO: begin
                    {r_cy, r_res[LO_W-1:0]} <= w_lo_sum;
                end
                S_ADD_HI: begin
                    r_res[PROD_W-1:LO_W] <= w_hi_sum;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.pp        = r_pp;
    assign bus.out_valid = r_out_valid;
    assign bus.out_prod  = r_res;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mul16x9_seq.sv
// Self-checking bench for mul16x9_seq: models the external CSA as a random
// sum/carry split of the shifted partial-product total, and checks products
// against plain a*b arithmetic.
module tb_mul16x9_seq;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [31:0] csa_seed;
    logic [31:0] exp_q[$];

    mul16x9_seq_if bus();

    mul16x9_seq #(.LO_W(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External CSA model: any redundant pair whose sum equals the weighted
    // partial-product total, with a random split so carries cross LO_W
    always_comb begin
        logic [31:0] p;
        logic [31:0] lim;
        logic [31:0] s;
        p = 32'h0;
        for (int i = 0; i < 9; i++) p = p + (32'(bus.pp[i]) << i);
        lim = (p < 32'h00FF_FFFF) ? p : 32'h00FF_FFFF;
        s = csa_seed % (lim + 32'd1);
        if (s[0] != p[0]) s = (s != 32'h0) ? s - 32'd1 : s + 32'd1;
        bus.csa_sum   = s[23:0];
        bus.csa_carry = 25'(p - s);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one operand pair and return just after the accept edge
    task automatic accept(input logic [15:0] a, input logic [8:0] b);
        int n;
        csa_seed     = $urandom;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("accept_timeout", 32'(n), 32'd0);
        tick();
        bus.in_valid = 1'b0;
        exp_q.push_back(32'(a) * 32'(b));
    endtask

    // Cycles from accept edge until out_valid is seen
    task automatic wait_valid(input bit rand_ready, output int lat);
        int n;
        n = 1;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        lat = n;
    endtask

    // Drive out_ready until the product handshake, checking the held product
    task automatic drain(input string tag, input bit rand_ready);
        logic [31:0] e;
        int n;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        n = 0;
        forever begin
            bus.out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (n > 10) bus.out_ready = 1'b1;
            check({tag, "_prod"}, 32'(bus.out_prod), e);
            tick();
            n++;
            if (bus.out_ready) break;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        end
        check({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        n_cmp = 0;
        n_err = 0;
        csa_seed      = 32'h0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = 16'h0;
        bus.in_b      = 9'h0;
        bus.out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_prod", 32'(bus.out_prod), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_pp", 32'(|bus.pp), 32'd0);
        rst_n = 1'b1;
        tick();

        // Full-scale single op
        bus.out_ready = 1'b1;
        accept(16'hFFFF, 9'h1FF);
        check("max_busy", 32'(bus.busy), 32'd1);
        check("max_in_ready", 32'(bus.in_ready), 32'd0);
        wait_valid(1'b0, lat);
        check("max_latency", 32'(lat), 32'd4);
        check("max_prod_const", 32'(bus.out_prod), 32'h01FE_FE01);
        drain("max", 1'b0);

        // Partial-product gating
        accept(16'h1234, 9'h005);
        for (int i = 0; i < 9; i++)
            check($sformatf("pp%0d_in_pp", i), 32'(bus.pp[i]),
                  (i == 0 || i == 2) ? 32'h1234 : 32'h0);
        tick();
        check("pp_after_pp", 32'(|bus.pp), 32'd0);
        wait_valid(1'b0, lat);
        check("gate_latency", 32'(lat), 32'd3);
        check("pp_in_done", 32'(|bus.pp), 32'd0);
        check("gate_prod_const", 32'(bus.out_prod), 32'h5B04);
        drain("gate", 1'b0);

        // Back-pressure: product held, extra in_valid ignored
        bus.out_ready = 1'b0;
        accept(16'h8000, 9'h100);
        wait_valid(1'b0, lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'($urandom_range(0, 1)) | (i == 0);
            bus.in_a     = 16'hAAAA;
            bus.in_b     = 9'h155;
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_out_prod", 32'(bus.out_prod), 32'h0080_0000);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            tick();
        end
        bus.in_valid = 1'b0;
        drain("bp", 1'b0);
        tick();
        check("bp_no_extra_op", 32'(bus.busy), 32'd0);

        // Carry across the low/high split
        accept(16'h0FFF, 9'h001);
        wait_valid(1'b0, lat);
        check("cy1_latency", 32'(lat), 32'd4);
        check("cy1_prod_const", 32'(bus.out_prod), 32'h0FFF);
        drain("cy1", 1'b0);
        accept(16'hFFFF, 9'h003);
        wait_valid(1'b0, lat);
        check("cy2_latency", 32'(lat), 32'd4);
        check("cy2_prod_const", 32'(bus.out_prod), 32'h2FFFD);
        drain("cy2", 1'b0);

        // Reset during ADD_LO drops the result
        accept(16'h0FFF, 9'h1FF);
        void'(exp_q.pop_back());
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("mrst_busy", 32'(bus.busy), 32'd0);
        check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("mrst_out_prod", 32'(bus.out_prod), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("mrst_no_pulse", 32'(bus.out_valid), 32'd0);
        end
        accept(16'd3, 9'd5);
        wait_valid(1'b0, lat);
        check("mrst_latency", 32'(lat), 32'd4);
        check("mrst_prod_const", 32'(bus.out_prod), 32'd15);
        drain("mrst", 1'b0);

        // Random operands, gaps and back-pressure
        for (int k = 0; k < 1000; k++) begin
            logic [15:0] a;
            logic [8:0]  b;
            int gap;
            a = 16'($urandom);
            b = 9'($urandom);
            if (k % 17 == 0) a = 16'h0;
            if (k % 19 == 0) b = 9'h0;
            gap = $urandom_range(0, 3);
            bus.out_ready = 1'($urandom_range(0, 1));
            for (int g = 0; g < gap; g++) tick();
            accept(a, b);
            wait_valid(1'b1, lat);
            check("rnd_latency", 32'(lat), 32'd4);
            drain("rnd", 1'b1);
        end
        check("rnd_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
